// File: rtl/dcache_refill_ctrl_if.sv
// Bundle of the CPU request/response, cache lookup/update and memory
// request/response channels of the data-cache refill controller.
// slave  : the controller itself
// master : the environment (CPU, cache array, memory) driving it
interface dcache_refill_ctrl_if;
  // CPU request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  // CPU response channel
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  // Cache lookup and update
  logic [63:0] cache_raddr;
  logic        cache_hit;
  logic [63:0] cache_rdata;
  logic        cache_upd;
  logic        cache_winv;
  logic [63:0] cache_waddr;
  logic [63:0] cache_wdata;
  // Memory request channel
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [63:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  // Memory response channel
  logic        mem_resp_valid;
  logic [63:0] mem_resp_rdata;
  logic        mem_resp_err;

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask,
    input  resp_ready,
    input  cache_hit, cache_rdata,
    input  mem_req_ready,
    input  mem_resp_valid, mem_resp_rdata, mem_resp_err,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    output cache_raddr, cache_upd, cache_winv, cache_waddr, cache_wdata,
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask
  );

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask,
    output resp_ready,
    output cache_hit, cache_rdata,
    output mem_req_ready,
    output mem_resp_valid, mem_resp_rdata, mem_resp_err,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    input  cache_raddr, cache_upd, cache_winv, cache_waddr, cache_wdata,
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask
  );
endinterface

// File: rtl/dcache_refill_ctrl.sv
// Blocking load/store controller in front of the small data cache.
// Loads look up the cache and refill it from memory on a miss; stores
// write through to memory and invalidate the matching line.
// Optional feature macro: DCACHE_MMIO_BYPASS_EN -- when defined, loads at
// or above MMIO_BASE skip the cache lookup and never refill the cache.
module dcache_refill_ctrl #(
  parameter logic [63:0] MMIO_BASE = 64'h0000_0000_A000_0000
) (
  input logic               clk,
  input logic               rst,
  dcache_refill_ctrl_if.slave bus_if
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MREQ   = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic        wen_q, wen_d;
  logic        byp_q, byp_d;
  logic [63:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        cache_upd;
  logic        cache_winv;
  logic        req_is_mmio;

`ifdef DCACHE_MMIO_BYPASS_EN
  // Uncached region decode on the incoming address.
  assign req_is_mmio = (bus_if.req_addr >= MMIO_BASE);
`else
  // Every address is cacheable; the base is kept only so both builds share one parameter list.
  logic unused_mmio_base;
  assign unused_mmio_base = ^MMIO_BASE;
  assign req_is_mmio      = 1'b0;
`endif

  // State and latched request/response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wen_q   <= 1'b0;
      byp_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      wen_q   <= wen_d;
      byp_q   <= byp_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and the one-cycle cache update/invalidate pulses.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    wen_d      = wen_q;
    byp_d      = byp_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cache_upd  = 1'b0;
    cache_winv = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus_if.req_valid) begin
          addr_d  = bus_if.req_addr;
          wdata_d = bus_if.req_wdata;
          wmask_d = bus_if.req_wmask;
          wen_d   = bus_if.req_wen;
          // Only loads are affected by the uncached region; stores always write through.
          byp_d   = !bus_if.req_wen && req_is_mmio;
          if (bus_if.req_wen || byp_d) begin
            state_d = S_MREQ;
          end else begin
            state_d = S_LOOKUP;
          end
        end
      end

      S_LOOKUP: begin
        if (bus_if.cache_hit) begin
          rdata_d = bus_if.cache_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          state_d = S_MREQ;
        end
      end

      S_MREQ: begin
        if (bus_if.mem_req_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus_if.mem_resp_valid) begin
          // Stores return zero data; errored loads still return the raw memory word.
          rdata_d    = wen_q ? 64'd0 : bus_if.mem_resp_rdata;
          err_d      = bus_if.mem_resp_err;
          cache_upd  = !wen_q && !bus_if.mem_resp_err && !byp_q;
          cache_winv = wen_q;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        if (bus_if.resp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs come straight from the state; data outputs come from
  // registers so they stay stable while waiting for the other side.
  assign bus_if.req_ready     = (state_q == S_IDLE);
  assign bus_if.resp_valid    = (state_q == S_RESP);
  assign bus_if.resp_rdata    = rdata_q;
  assign bus_if.resp_err      = err_q;

  assign bus_if.cache_raddr   = addr_q;
  assign bus_if.cache_upd     = cache_upd;
  assign bus_if.cache_winv    = cache_winv;
  assign bus_if.cache_waddr   = {addr_q[63:3], 3'b000};
  assign bus_if.cache_wdata   = cache_upd ? bus_if.mem_resp_rdata : 64'd0;

  assign bus_if.mem_req_valid = (state_q == S_MREQ);
  assign bus_if.mem_req_wen   = wen_q;
  assign bus_if.mem_req_addr  = addr_q;
  assign bus_if.mem_req_wdata = wdata_q;
  assign bus_if.mem_req_wmask = wmask_q;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Scoreboard bench for dcache_refill_ctrl: the stimulus process pushes the
// expected memory requests, cache pulses and CPU responses; a negedge
// monitor pops and compares them as the handshakes happen.
module tb_dcache_refill_ctrl;

  localparam logic [63:0] MMIO_BASE = 64'h0000_0000_A000_0000;
`ifdef DCACHE_MMIO_BYPASS_EN
  localparam bit BYP_EN = 1'b1;
`else
  localparam bit BYP_EN = 1'b0;
`endif

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } mem_exp_t;

  typedef struct {
    logic        upd;
    logic [63:0] waddr;
    logic [63:0] wdata;
  } cache_exp_t;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
  } resp_exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_exp_t   mem_q[$];
  cache_exp_t cache_q[$];
  resp_exp_t  resp_q[$];

  dcache_refill_ctrl_if bus();

  dcache_refill_ctrl #(.MMIO_BASE(MMIO_BASE)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every handshake/pulse against the scoreboard queues.
  always @(negedge clk) begin
    if (bus.mem_req_valid && bus.mem_req_ready) begin
      if (mem_q.size() == 0) begin
        chk("mem_unexpected", 64'd1, 64'd0);
      end else begin
        mem_exp_t m;
        m = mem_q.pop_front();
        chk("mem_wen", bus.mem_req_wen, m.wen);
        chk("mem_addr", bus.mem_req_addr, m.addr);
        chk("mem_wdata", bus.mem_req_wdata, m.wdata);
        chk("mem_wmask", bus.mem_req_wmask, m.wmask);
        $display("mem req wen=%0d addr=%h wdata=%h wmask=%h", bus.mem_req_wen,
                 bus.mem_req_addr, bus.mem_req_wdata, bus.mem_req_wmask);
      end
    end
    if (bus.cache_upd || bus.cache_winv) begin
      chk("cache_excl", bus.cache_upd & bus.cache_winv, 64'd0);
      if (cache_q.size() == 0) begin
        chk("cache_unexpected", 64'd1, 64'd0);
      end else begin
        cache_exp_t c;
        c = cache_q.pop_front();
        chk("cache_kind_upd", bus.cache_upd, c.upd);
        chk("cache_waddr", bus.cache_waddr, c.waddr);
        if (c.upd) chk("cache_wdata", bus.cache_wdata, c.wdata);
        $display("cache upd=%0d winv=%0d waddr=%h wdata=%h", bus.cache_upd,
                 bus.cache_winv, bus.cache_waddr, bus.cache_wdata);
      end
    end
    if (bus.resp_valid && bus.resp_ready) begin
      if (resp_q.size() == 0) begin
        chk("resp_unexpected", 64'd1, 64'd0);
      end else begin
        resp_exp_t r;
        r = resp_q.pop_front();
        chk("resp_rdata", bus.resp_rdata, r.rdata);
        chk("resp_err", bus.resp_err, r.err);
        $display("resp rdata=%h err=%0d", bus.resp_rdata, bus.resp_err);
      end
    end
  end

  // One complete CPU transaction with configurable back-pressure.
  task automatic run_txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [7:0] wmask, input logic hit, input logic [63:0] hdata,
                         input logic [63:0] mdata, input logic merr,
                         input int rdy_dly, input int resp_dly);
    bit          byp;
    bit          use_mem;
    int          n;
    mem_exp_t    m;
    cache_exp_t  c;
    resp_exp_t   r;
    logic [63:0] exp_rdata;
    logic        exp_err;

    byp     = BYP_EN && !wen && (addr >= MMIO_BASE);
    use_mem = wen || byp || !hit;
    exp_rdata = wen ? 64'd0 : (use_mem ? mdata : hdata);
    exp_err   = use_mem ? merr : 1'b0;

    if (use_mem) begin
      m.wen = wen; m.addr = addr; m.wdata = wdata; m.wmask = wmask;
      mem_q.push_back(m);
      if (wen || (!merr && !byp)) begin
        c.upd = !wen; c.waddr = {addr[63:3], 3'b000}; c.wdata = mdata;
        cache_q.push_back(c);
      end
    end
    r.rdata = exp_rdata; r.err = exp_err;
    resp_q.push_back(r);

    bus.req_valid   = 1'b1;
    bus.req_wen     = wen;
    bus.req_addr    = addr;
    bus.req_wdata   = wdata;
    bus.req_wmask   = wmask;
    bus.cache_hit   = hit;
    bus.cache_rdata = hdata;
    chk("req_ready_idle", bus.req_ready, 64'd1);
    tick();
    bus.req_valid = 1'b0;

    if (!use_mem) begin
      chk("lookup_no_resp", bus.resp_valid, 64'd0);
      chk("lookup_no_mem", bus.mem_req_valid, 64'd0);
      tick();
      chk("hit_latency", bus.resp_valid, 64'd1);
    end else begin
      // Stores and bypassed loads go straight to memory; cached misses spend a cycle in lookup.
      chk("direct_to_mem", bus.mem_req_valid, (wen || byp) ? 64'd1 : 64'd0);
      n = 0;
      while (!bus.mem_req_valid && n < 10) begin
        tick();
        n++;
      end
      if (!bus.mem_req_valid) chk("mem_req_timeout", 64'd1, 64'd0);
      for (int i = 0; i < rdy_dly; i++) begin
        chk("mem_hold_valid", bus.mem_req_valid, 64'd1);
        chk("mem_hold_addr", bus.mem_req_addr, addr);
        chk("mem_hold_wdata", bus.mem_req_wdata, wdata);
        chk("mem_hold_wmask", bus.mem_req_wmask, wmask);
        tick();
      end
      bus.mem_req_ready = 1'b1;
      tick();
      bus.mem_req_ready = 1'b0;
      chk("mem_req_dropped", bus.mem_req_valid, 64'd0);
      tick();
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = mdata;
      bus.mem_resp_err   = merr;
      tick();
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = 64'd0;
      bus.mem_resp_err   = 1'b0;
    end

    n = 0;
    while (!bus.resp_valid && n < 10) begin
      tick();
      n++;
    end
    if (!bus.resp_valid) chk("resp_timeout", 64'd1, 64'd0);
    for (int i = 0; i < resp_dly; i++) begin
      chk("resp_hold_valid", bus.resp_valid, 64'd1);
      chk("resp_hold_rdata", bus.resp_rdata, exp_rdata);
      chk("resp_hold_err", bus.resp_err, exp_err);
      tick();
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    bus.cache_hit  = 1'b0;
    chk("back_to_back_ready", bus.req_ready, 64'd1);
    chk("resp_dropped", bus.resp_valid, 64'd0);
  endtask

  initial begin
    mem_exp_t m;
    int       n;
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid      = 1'b0;
    bus.req_wen        = 1'b0;
    bus.req_addr       = 64'd0;
    bus.req_wdata      = 64'd0;
    bus.req_wmask      = 8'd0;
    bus.resp_ready     = 1'b0;
    bus.cache_hit      = 1'b0;
    bus.cache_rdata    = 64'd0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = 64'd0;
    bus.mem_resp_err   = 1'b0;

    repeat (3) tick();
    chk("rst_req_ready", bus.req_ready, 64'd1);
    chk("rst_resp_valid", bus.resp_valid, 64'd0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 64'd0);
    chk("rst_cache_upd", bus.cache_upd, 64'd0);
    chk("rst_cache_winv", bus.cache_winv, 64'd0);
    chk("rst_mem_req_addr", bus.mem_req_addr, 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_cache_waddr", bus.cache_waddr, 64'd0);
    rst = 1'b0;
    tick();

    // 1: load miss with refill
    run_txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 1'b0, 64'd0,
            64'h1122_3344_5566_7788, 1'b0, 0, 0);
    // 2: same load, cache hit
    run_txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 1'b1, 64'h1122_3344_5566_7788,
            64'd0, 1'b0, 0, 0);
    // 3: store write-through with invalidate
    run_txn(1'b1, 64'h8000_0014, 64'h0000_00AB_0000_0000, 8'hF0, 1'b0, 64'd0,
            64'h5555_5555_5555_5555, 1'b0, 0, 0);
    // 4: load miss with memory error, no refill
    run_txn(1'b0, 64'h8000_0028, 64'd0, 8'h00, 1'b0, 64'd0,
            64'hDEAD_BEEF_0BAD_F00D, 1'b1, 0, 0);
    // store with memory error still invalidates
    run_txn(1'b1, 64'h8000_0038, 64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0, 64'd0,
            64'd0, 1'b1, 1, 0);
    // 5: back-pressure on both memory request and CPU response
    run_txn(1'b0, 64'h8000_0047, 64'd0, 8'h00, 1'b0, 64'd0,
            64'hCAFE_F00D_1234_5678, 1'b0, 5, 3);
    // 6b: load from the start of the uncached region with the cache claiming a hit
    run_txn(1'b0, 64'h0000_0000_A000_0000, 64'd0, 8'h00, 1'b1, 64'h7777_7777_7777_7777,
            64'h0A0A_0B0B_0C0C_0D0D, 1'b0, 0, 0);
    // just below the uncached region is always cached
    run_txn(1'b0, 64'h0000_0000_9FFF_FFF8, 64'd0, 8'h00, 1'b1, 64'h3333_4444_5555_6666,
            64'd0, 1'b0, 0, 0);

    // 6: reset while waiting for the memory response
    m.wen = 1'b0; m.addr = 64'h8000_0100; m.wdata = 64'd0; m.wmask = 8'h00;
    mem_q.push_back(m);
    bus.req_valid = 1'b1;
    bus.req_wen   = 1'b0;
    bus.req_addr  = 64'h8000_0100;
    bus.req_wdata = 64'd0;
    bus.req_wmask = 8'h00;
    tick();
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.mem_req_valid && n < 10) begin
      tick();
      n++;
    end
    if (!bus.mem_req_valid) chk("rst_test_mem_timeout", 64'd1, 64'd0);
    bus.mem_req_ready = 1'b1;
    tick();
    bus.mem_req_ready = 1'b0;
    chk("in_wait_not_ready", bus.req_ready, 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_req_ready", bus.req_ready, 64'd1);
    chk("midrst_mem_req_valid", bus.mem_req_valid, 64'd0);
    chk("midrst_resp_valid", bus.resp_valid, 64'd0);
    $display("mid-operation reset: req_ready=%0d mem_req_valid=%0d resp_valid=%0d",
             bus.req_ready, bus.mem_req_valid, bus.resp_valid);

    // a normal transaction after the abandoned one
    run_txn(1'b0, 64'h8000_0200, 64'd0, 8'h00, 1'b0, 64'd0,
            64'hFEED_FACE_0000_0001, 1'b0, 0, 1);

    repeat (3) tick();
    chk("leftover_mem", mem_q.size(), 64'd0);
    chk("leftover_cache", cache_q.size(), 64'd0);
    chk("leftover_resp", resp_q.size(), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_refill_ctrl.md
Name:
dcache_refill_ctrl

Overview:
Blocking load/store controller sitting directly in front of the 2-way, 4-set, 8-byte-line data cache. It accepts one CPU memory request at a time and looks the address up in the cache. On a read miss it fetches the 64-bit word from memory, refills the cache and returns the data. On a store it writes through to memory and invalidates the matching cache set.

Parameters:
MMIO_BASE, 64'h0000_0000_A000_0000, addresses >= this are uncached when the bypass feature is compiled in.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_valid  in  1  CPU request valid
req_ready  out  1  controller can accept a request (high only in IDLE)
req_wen  in  1  1 = store, 0 = load
req_addr  in  64  byte address
req_wdata  in  64  store data, lane-aligned
req_wmask  in  8  store byte strobes
resp_valid  out  1  response valid, held until resp_ready
resp_ready  in  1  CPU accepts response
resp_rdata  out  64  load word at {addr[63:3],3'b0}; 0 for stores
resp_err  out  1  memory returned an error
cache_raddr  out  64  cache lookup address (latched req_addr)
cache_hit  in  1  cache hit, combinational from cache_raddr
cache_rdata  in  64  cache hit data
cache_upd  out  1  one-cycle refill pulse
cache_winv  out  1  one-cycle invalidate pulse
cache_waddr  out  64  address for refill and invalidate, 8-byte aligned
cache_wdata  out  64  refill data
mem_req_valid  out  1  memory request valid, held until mem_req_ready
mem_req_ready  in  1  memory accepts request
mem_req_wen  out  1  memory write
mem_req_addr  out  64  memory address (latched req_addr, unmodified)
mem_req_wdata  out  64  write data
mem_req_wmask  out  8  write strobes
mem_resp_valid  in  1  memory response, one-cycle pulse, always accepted in WAIT
mem_resp_rdata  in  64  read data
mem_resp_err  in  1  memory error

Behaviour:
- Reset: state IDLE. req_ready=1; resp_valid, cache_upd, cache_winv and mem_req_valid are 0. All data and address outputs are 0.
- States:
  - IDLE: on req_valid, latch addr, wdata, wmask and wen. A load goes to LOOKUP. A store goes to MREQ.
  - LOOKUP (one cycle, cache_raddr = latched addr): on cache_hit, latch cache_rdata and go to RESP. Otherwise go to MREQ.
  - MREQ: assert mem_req_valid. On mem_req_ready, go to WAIT.
  - WAIT: on mem_resp_valid, latch rdata and err, then go to RESP.
  - RESP: assert resp_valid. On resp_ready, go to IDLE.
- Load hit latency: request accepted in cycle 0, LOOKUP in cycle 1, resp_valid in cycle 2. A back-to-back request is accepted no earlier than the cycle after the resp handshake.
- Refill: pulse cache_upd in the WAIT->RESP cycle for a load with mem_resp_err=0 and a cacheable address. cache_waddr={addr[63:3],3'b0} and cache_wdata=mem_resp_rdata.
- Store: pulse cache_winv in the WAIT->RESP cycle regardless of err. resp_rdata=0.
- Mutual exclusion: cache_upd and cache_winv are never high in the same cycle.
- Error: resp_err=1 on a memory error. No refill occurs on error. resp_rdata is the raw mem data.
- Output stability: all mem_req_* and resp_* outputs stay stable while valid and not yet handshaked.
- Reset mid-operation: the FSM returns to IDLE on the next edge and the outstanding memory transaction is abandoned. The memory side shares the same rst.

Optional Feature:
- Macro: DCACHE_MMIO_BYPASS_EN.
- Defined: a load with addr >= MMIO_BASE skips LOOKUP (IDLE->MREQ) and never pulses cache_upd. Stores behave as normal.
- Undefined: all addresses are cacheable and MMIO_BASE is unused.

Test Plan:
1. Load 0x8000_0010 with the cache missing and mem returning 0x1122334455667788 -> one mem read. cache_upd pulses with waddr 0x8000_0010. resp_rdata=0x1122334455667788, err=0.
2. Repeat the same load with cache_hit=1 -> no mem_req_valid. resp_valid occurs 2 cycles after acceptance with the cache data.
3. Store to 0x8000_0014, wdata 0xAB<<32, wmask 0xF0 -> mem write with the same addr, data and mask. cache_winv pulses with waddr 0x8000_0010. resp_rdata=0.
4. Load miss with mem_resp_err=1 -> resp_err=1 and no cache_upd.
5. Hold mem_req_ready=0 for 5 cycles and resp_ready=0 for 3 cycles -> outputs stay stable and exactly one handshake each.
6. Assert rst while in WAIT -> next cycle req_ready=1, mem_req_valid=0, resp_valid=0. With DCACHE_MMIO_BYPASS_EN, a load from 0xA000_0000 produces no LOOKUP and no cache_upd.
